fetch: RTL and testbench

Instruction fetch stage of the pipelined Beta core. It is the producer end of the fetch→decode interface. It owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small prefetch FIFO, and each cycle one instruction plus its PC+4 goes to decode. It takes JMP/BEQ/BNE redirects and the stall signal back from decode, and takes interrupt requests from control.

---
 rtl/fetch.sv | 181 ++++++++++++++++++
 tb/tb_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch stage of the pipelined Beta core.
// Owns the PC, issues word reads over a req/gnt/rvalid handshake, buffers
// returned words in a prefetch FIFO and presents one instruction plus its
// PC+4 to decode per cycle. Decode redirects (JMP/BEQ/BNE) and interrupts
// flush the FIFO; responses already in flight are counted off and dropped.

`ifndef INST_NOP
`define INST_NOP 32'hC3FF_0000
`endif

module fetch #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] XADDR_VEC = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        stall,
  input  logic        op_jmp,
  input  logic        op_beq,
  input  logic        op_bne,
  input  logic        zr,
  input  logic [31:0] j_addr,
  input  logic [31:0] br_addr,
  input  logic        irq,
  output logic        irq_taken
);

  // Pointer width for the FIFO / address queue, and a counter width that
  // can hold the value DEPTH itself.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Architectural fetch state.
  logic [31:0]   r_fetchPc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [31:0]   r_lastPc;

  // Prefetch FIFO: PC+4 and instruction word per entry.
  logic [31:0]   r_fifoPc [DEPTH];
  logic [31:0]   r_fifoIr [DEPTH];
  logic [PW-1:0] r_fifoRd;
  logic [PW-1:0] r_fifoWr;
  logic [CW-1:0] r_count;

  // Address queue: one entry per granted request, retired by rvalid in order.
  logic [31:0]   r_aq [DEPTH];
  logic [PW-1:0] r_aqRd;
  logic [PW-1:0] r_aqWr;

  logic [31:0]   w_headPc;
  logic [31:0]   w_headIr;
  logic          w_headValid;
  logic [CW:0]   w_inFlight;
  logic          w_canIssue;
  logic          w_accept;
  logic          w_rspFire;
  logic          w_taken;
  logic          w_redirect;
  logic          w_irqTake;
  logic          w_flush;
  logic [31:0]   w_brTarget;
  logic [31:0]   w_flushTarget;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_outNext;

  // Redirect / interrupt decisions; both are ignored while decode stalls,
  // and a taken branch wins over a pending interrupt.
  assign w_taken       = op_jmp | (op_beq & zr) | (op_bne & ~zr);
  assign w_redirect    = ~stall & w_taken;
  assign w_irqTake     = irq & ~stall & ~w_taken;
  assign w_flush       = w_redirect | w_irqTake;
  assign w_brTarget    = op_jmp ? (j_addr & ~32'h3) : br_addr;
  assign w_flushTarget = w_redirect ? w_brTarget : XADDR_VEC;

  // Issue is allowed while buffered plus outstanding words leave room in the
  // FIFO. That sum never grows without a grant, so req stays up until gnt
  // except when a flush withdraws it.
  assign w_inFlight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_canIssue = w_inFlight < DEPTH_C;
  assign w_accept   = imem_gnt & w_canIssue;
  assign w_rspFire  = imem_rvalid & (r_outstanding != '0);
  assign w_outNext  = r_outstanding + {{(CW-1){1'b0}}, w_accept}
                                    - {{(CW-1){1'b0}}, w_rspFire};

  // FIFO head presentation; the redirect slot is annulled.
  assign w_headValid = (r_count != '0);
  assign w_headPc    = r_fifoPc[r_fifoRd];
  assign w_headIr    = r_fifoIr[r_fifoRd];
  assign w_push      = w_rspFire & (r_discard == '0) & ~w_flush;
  assign w_pop       = w_headValid & ~stall & ~w_flush;

  assign imem_req  = rst_n & w_canIssue & ~w_flush;
  assign imem_addr = r_fetchPc;
  assign ir_valid  = w_headValid & ~w_flush;
  assign ir        = ir_valid ? w_headIr : `INST_NOP;
  assign pc        = w_headValid ? w_headPc : r_lastPc;
  assign irq_taken = rst_n & w_irqTake;

  // PC, outstanding/discard accounting and last-presented PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc     <= RESET_VEC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_lastPc      <= 32'h0;
    end else begin
      r_outstanding <= w_outNext;
      if (w_flush) begin
        r_fetchPc <= w_flushTarget;
        r_discard <= w_outNext;
      end else begin
        if (w_accept) begin
          r_fetchPc <= r_fetchPc + 32'd4;
        end
        if (w_rspFire && (r_discard != '0)) begin
          r_discard <= r_discard - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      if (ir_valid) begin
        r_lastPc <= w_headPc;
      end
    end
  end

  // FIFO and address-queue pointers; only the FIFO is emptied by a flush,
  // the address queue keeps pairing discarded responses with their requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifoRd <= '0;
      r_fifoWr <= '0;
      r_count  <= '0;
      r_aqRd   <= '0;
      r_aqWr   <= '0;
    end else begin
      if (w_flush) begin
        r_fifoRd <= '0;
        r_fifoWr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_fifoWr <= r_fifoWr + PW'(1);
        end
        if (w_pop) begin
          r_fifoRd <= r_fifoRd + PW'(1);
        end
        r_count <= r_count + {{(CW-1){1'b0}}, w_push}
                           - {{(CW-1){1'b0}}, w_pop};
      end
      if (w_accept) begin
        r_aqWr <= r_aqWr + PW'(1);
      end
      if (w_rspFire) begin
        r_aqRd <= r_aqRd + PW'(1);
      end
    end
  end

  // Data storage needs no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoPc[r_fifoWr] <= r_aq[r_aqRd] + 32'd4;
      r_fifoIr[r_fifoWr] <= imem_rdata;
    end
    if (w_accept) begin
      r_aq[r_aqWr] <= r_fetchPc;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage with a simple in-order memory model.
// Memory word at address A is 0x6000_0000 + (A - 0x8000_0000)/4.

module tb_fetch;

  localparam logic [31:0] NOP = 32'hC3FF_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        stall;
  logic        op_jmp;
  logic        op_beq;
  logic        op_bne;
  logic        zr;
  logic [31:0] j_addr;
  logic [31:0] br_addr;
  logic        irq;
  logic        irq_taken;

  logic        gntEn;
  logic        respEn;
  logic [31:0] pendQ[$];
  int          total;
  int          bad;

  fetch #(
    .DEPTH(4),
    .RESET_VEC(32'h8000_0000),
    .XADDR_VEC(32'h8000_0008)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .pc(pc),
    .ir(ir),
    .ir_valid(ir_valid),
    .stall(stall),
    .op_jmp(op_jmp),
    .op_beq(op_beq),
    .op_bne(op_bne),
    .zr(zr),
    .j_addr(j_addr),
    .br_addr(br_addr),
    .irq(irq),
    .irq_taken(irq_taken)
  );

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return 32'h6000_0000 + ((a - 32'h8000_0000) >> 2);
  endfunction

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory grants whenever enabled; it keeps no reset so late responses survive.
  assign imem_gnt = gntEn & imem_req;

  // Record each granted address in order.
  always @(posedge clk) begin
    if (imem_req && imem_gnt) pendQ.push_back(imem_addr);
  end

  // Return one word per cycle, at least one cycle after its grant.
  always @(negedge clk) begin
    if (respEn && pendQ.size() > 0) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= memFn(pendQ.pop_front());
    end else begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic j, input logic beq,
                               input logic bne, input logic z, input logic irqIn);
    @(negedge clk);
    stall  = s;
    op_jmp = j;
    op_beq = beq;
    op_bne = bne;
    zr     = z;
    irq    = irqIn;
    #1;
  endtask

  // Pulse reset, let any late responses drain, then enable grants.
  task automatic resetDut(input logic respAfter);
    gntEn  = 1'b0;
    respEn = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstReq", {31'h0, imem_req}, 32'h0);
    checkOutput("rstValid", {31'h0, ir_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pendQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drainDone", pendQ.size(), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("drainValid", {31'h0, ir_valid}, 32'h0);
    gntEn  = 1'b1;
    respEn = respAfter;
  endtask

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; stall = 1'b0; op_jmp = 1'b0; op_beq = 1'b0;
    op_bne = 1'b0; zr = 1'b0; irq = 1'b0; j_addr = 32'h0; br_addr = 32'h0;
    gntEn = 1'b0; respEn = 1'b1; total = 0; bad = 0;
    #1;
    checkOutput("resetReq", {31'h0, imem_req}, 32'h0);
    checkOutput("resetValid", {31'h0, ir_valid}, 32'h0);
    checkOutput("resetIr", ir, NOP);
    checkOutput("resetPc", pc, 32'h0);
    checkOutput("resetIrq", {31'h0, irq_taken}, 32'h0);

    // Sequential stream from the reset vector
    resetDut(1'b1);
    checkOutput("seq0Req", {31'h0, imem_req}, 32'h1);
    checkOutput("seq0Addr", imem_addr, 32'h8000_0000);
    checkOutput("seq0Valid", {31'h0, ir_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("seq1Addr", imem_addr, 32'h8000_0004);
    checkOutput("seq1Valid", {31'h0, ir_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("seq2Ir", ir, 32'h6000_0000);
    checkOutput("seq2Pc", pc, 32'h8000_0004);
    checkOutput("seq2Valid", {31'h0, ir_valid}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("seq3Ir", ir, 32'h6000_0001);
    checkOutput("seq3Pc", pc, 32'h8000_0008);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("seq4Ir", ir, 32'h6000_0002);
    checkOutput("seq4Pc", pc, 32'h8000_000C);

    // Stall for three cycles while the first instruction is presented
    resetDut(1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput($sformatf("stall%0dIr", k), ir, 32'h6000_0000);
      checkOutput($sformatf("stall%0dPc", k), pc, 32'h8000_0004);
      checkOutput($sformatf("stall%0dValid", k), {31'h0, ir_valid}, 32'h1);
    end
    checkOutput("stallFullReq", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("unstallIr", ir, 32'h6000_0000);
    checkOutput("unstallReq", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("postStallIr", ir, 32'h6000_0001);
    checkOutput("postStallPc", pc, 32'h8000_0008);
    checkOutput("postStallAddr", imem_addr, 32'h8000_0010);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("postStall2Ir", ir, 32'h6000_0002);
    checkOutput("postStall2Pc", pc, 32'h8000_000C);

    // Taken BEQ with two reads outstanding
    resetDut(1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("beqPreAddr", imem_addr, 32'h8000_0004);
    br_addr = 32'h8000_0100;
    applyStimulus(0, 0, 1, 0, 1, 0);
    checkOutput("beqValid", {31'h0, ir_valid}, 32'h0);
    checkOutput("beqIr", ir, NOP);
    checkOutput("beqReq", {31'h0, imem_req}, 32'h0);
    respEn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("beqTgtAddr", imem_addr, 32'h8000_0100);
    checkOutput("beqTgtReq", {31'h0, imem_req}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("beqDrop1", {31'h0, ir_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("beqDrop2", {31'h0, ir_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("beqFirstIr", ir, 32'h6000_0040);
    checkOutput("beqFirstPc", pc, 32'h8000_0104);
    checkOutput("beqFirstValid", {31'h0, ir_valid}, 32'h1);

    // BNE with zr=1 falls through; JMP drops the low address bits
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("bneIr", ir, 32'h6000_0041);
    checkOutput("bnePc", pc, 32'h8000_0108);
    checkOutput("bneValid", {31'h0, ir_valid}, 32'h1);
    j_addr = 32'h8000_0203;
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("jmpValid", {31'h0, ir_valid}, 32'h0);
    checkOutput("jmpReq", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("jmpAddr", imem_addr, 32'h8000_0200);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("jmpFirstIr", ir, 32'h6000_0080);
    checkOutput("jmpFirstPc", pc, 32'h8000_0204);

    // Interrupt collides with a taken branch, then waits through a stall
    br_addr = 32'h8000_0300;
    applyStimulus(0, 0, 1, 0, 1, 1);
    checkOutput("irqBranchTaken", {31'h0, irq_taken}, 32'h0);
    checkOutput("irqBranchValid", {31'h0, ir_valid}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("irqStallTaken", {31'h0, irq_taken}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("irqTaken", {31'h0, irq_taken}, 32'h1);
    checkOutput("irqReq", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("irqPulseEnd", {31'h0, irq_taken}, 32'h0);
    checkOutput("irqAddr", imem_addr, 32'h8000_0008);
    for (int i = 0; i < 10; i++) begin
      if (ir_valid) break;
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("irqWaitValid", {31'h0, ir_valid}, 32'h1);
    checkOutput("irqFirstIr", ir, 32'h6000_0002);
    checkOutput("irqFirstPc", pc, 32'h8000_000C);

    // Reset with two reads outstanding; their late data must be ignored
    resetDut(1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("midOutAddr", imem_addr, 32'h8000_0008);
    resetDut(1'b1);
    checkOutput("restartAddr", imem_addr, 32'h8000_0000);
    checkOutput("restartValid", {31'h0, ir_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("restart1Valid", {31'h0, ir_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("restartIr", ir, 32'h6000_0000);
    checkOutput("restartPc", pc, 32'h8000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
